// File: rtl/fractal_iter_ctrl.sv
// Escape-time fractal scan controller: walks every pixel of a frame, iterates z
// through a shared external step unit and streams one iteration count per pixel.
module fractal_iter_ctrl #(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int X_OFF    = 320,
    parameter int Y_OFF    = 240,
    parameter int MAX_ITER = 63,
    parameter int ITER_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       c,
    input  logic [31:0]       thres,
    output logic              busy,
    output logic              done,
    output logic [31:0]       step_z,
    input  logic [31:0]       step_zz,
    input  logic [31:0]       step_az,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [11:0]       pix_x,
    output logic [11:0]       pix_y,
    output logic [ITER_W-1:0] pix_iter
);

    typedef enum logic [1:0] {IDLE, INIT, ITER, EMIT} state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       c_q;
    logic [31:0]       thres_q;
    logic [31:0]       z;
    logic [11:0]       x;
    logic [11:0]       y;
    logic [11:0]       x_rel;
    logic [11:0]       y_rel;
    logic [ITER_W-1:0] iter;
    logic [ITER_W-1:0] result;
    logic              escape;
    logic              handshake;
    logic              last_x;
    logic              last_y;

    assign escape    = (step_az >= thres_q) || (iter == ITER_W'(MAX_ITER));
    assign handshake = (state == EMIT) && pix_ready;
    assign last_x    = (x == 12'(H_RES - 1));
    assign last_y    = (y == 12'(V_RES - 1));
    assign x_rel     = x - 12'(X_OFF);
    assign y_rel     = y - 12'(Y_OFF);

    // Valid comes purely from registered state, so it can never follow ready.
    assign pix_valid = (state == EMIT);
    assign pix_x     = x;
    assign pix_y     = y;
    assign pix_iter  = result;
    assign step_z    = z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = INIT;
            INIT:    state_next = ITER;
            ITER:    if (escape) state_next = EMIT;
            EMIT:    if (handshake) state_next = (last_x && last_y) ? IDLE : INIT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= '0;
            thres_q <= '0;
            z       <= '0;
            x       <= '0;
            y       <= '0;
            iter    <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        c_q     <= c;
                        thres_q <= thres;
                        x       <= '0;
                        y       <= '0;
                        busy    <= 1'b1;
                    end
                end
                INIT: begin
                    z    <= {4'h0, y_rel, 4'h0, x_rel};
                    iter <= '0;
                end
                ITER: begin
                    // Real and imaginary halves wrap independently.
                    if (escape) begin
                        result <= iter;
                    end else begin
                        z    <= {step_zz[31:16] + c_q[31:16], step_zz[15:0] + c_q[15:0]};
                        iter <= iter + ITER_W'(1);
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        if (!last_x) begin
                            x <= x + 12'd1;
                        end else if (!last_y) begin
                            x <= '0;
                            y <= y + 12'd1;
                        end else begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fractal_iter_ctrl.sv
// Scoreboard bench for fractal_iter_ctrl: a small frame, a bench-side step unit
// and a plain-arithmetic escape-time model feeding an expected-result queue.
module tb_fractal_iter_ctrl;

    localparam int H_RES    = 4;
    localparam int V_RES    = 2;
    localparam int X_OFF    = 2;
    localparam int Y_OFF    = 1;
    localparam int MAX_ITER = 63;
    localparam int ITER_W   = 6;

    typedef struct {
        int x;
        int y;
        int it;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       c = '0;
    logic [31:0]       thres = '0;
    logic              busy;
    logic              done;
    logic [31:0]       step_z;
    logic [31:0]       step_zz;
    logic [31:0]       step_az;
    logic              pix_valid;
    logic              pix_ready = 1'b0;
    logic [11:0]       pix_x;
    logic [11:0]       pix_y;
    logic [ITER_W-1:0] pix_iter;

    int   errors = 0;
    int   checks = 0;
    int   mode = 0;
    bit   ready_rand = 0;
    bit   ready_force = 1;
    bit   gap_en = 0;
    bit   have_last = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    exp_t sb[$];

    fractal_iter_ctrl #(
        .H_RES(H_RES), .V_RES(V_RES), .X_OFF(X_OFF), .Y_OFF(Y_OFF),
        .MAX_ITER(MAX_ITER), .ITER_W(ITER_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .c(c), .thres(thres),
        .busy(busy), .done(done), .step_z(step_z), .step_zz(step_zz),
        .step_az(step_az), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_iter(pix_iter)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Q8.8 complex square and squared magnitude.
    function automatic logic [31:0] sq(input logic [31:0] z);
        longint re, im;
        re = longint'($signed(z[15:0]));
        im = longint'($signed(z[31:16]));
        return {16'((2 * re * im) >>> 8), 16'((re * re - im * im) >>> 8)};
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] z);
        longint re, im;
        re = longint'($signed(z[15:0]));
        im = longint'($signed(z[31:16]));
        return 32'((re * re + im * im) >>> 8);
    endfunction

    // Step unit modes: 0 real fractal, 1 identity stub, 2 never-escaping stub.
    always_comb begin
        step_zz = step_z;
        step_az = step_z;
        case (mode)
            0: begin step_zz = sq(step_z); step_az = mag(step_z); end
            2: begin step_zz = sq(step_z); step_az = 32'd0; end
            default: ;
        endcase
    end

    function automatic int iter_model(input int px, input int py, input logic [31:0] cc,
                                      input logic [31:0] th, input int md);
        logic [31:0] z, zz, az;
        z = {4'h0, 12'(py - Y_OFF), 4'h0, 12'(px - X_OFF)};
        for (int k = 0; k <= MAX_ITER; k++) begin
            zz = (md == 1) ? z : sq(z);
            az = (md == 0) ? mag(z) : ((md == 1) ? z : 32'd0);
            if (az >= th || k == MAX_ITER) return k;
            z = {zz[31:16] + cc[31:16], zz[15:0] + cc[15:0]};
        end
        return MAX_ITER;
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            pix_ready = ready_rand ? ($urandom_range(0, 2) != 0) : ready_force;
        end
    end

    // Monitor: pops on every handshake and checks hold-while-stalled behaviour.
    initial begin
        bit          prev_valid;
        bit          prev_hs;
        logic [11:0] px, py;
        logic [ITER_W-1:0] pit;
        exp_t        e;
        prev_valid = 0;
        prev_hs = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 0;
            end else begin
                if (prev_valid && !prev_hs) begin
                    checkOutput("valid_held", pix_valid, 1);
                    checkOutput("x_held", pix_x, px);
                    checkOutput("y_held", pix_y, py);
                    checkOutput("iter_held", pix_iter, pit);
                end
                if (pix_valid && pix_ready) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("pix_x", pix_x, e.x);
                        checkOutput("pix_y", pix_y, e.y);
                        checkOutput("pix_iter", pix_iter, e.it);
                        if (gap_en && have_last)
                            checkOutput("pixel_cycles", cyc - last_cyc, e.it + 3);
                        have_last = 1;
                        last_cyc = cyc;
                    end
                end
                if (done) done_cnt++;
                prev_valid = pix_valid;
                prev_hs = pix_valid && pix_ready;
                px = pix_x;
                py = pix_y;
                pit = pix_iter;
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] cc, input logic [31:0] th, input int md,
                                 input bit rrand, input bit rforce, input bit gap);
        exp_t e;
        mode = md;
        ready_rand = rrand;
        ready_force = rforce;
        gap_en = gap;
        have_last = 0;
        done_cnt = 0;
        for (int yy = 0; yy < V_RES; yy++)
            for (int xx = 0; xx < H_RES; xx++) begin
                e.x = xx;
                e.y = yy;
                e.it = iter_model(xx, yy, cc, th, md);
                sb.push_back(e);
            end
        @(posedge clk);
        #1;
        c = cc;
        thres = th;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("busy_after_start", busy, 1);
    endtask

    task automatic waitDone();
        for (int i = 0; i < 5000 && done_cnt == 0; i++) @(negedge clk);
        if (done_cnt == 0) checkOutput("frame_timeout", 0, 1);
        repeat (3) @(negedge clk);
        checkOutput("done_pulses", done_cnt, 1);
        checkOutput("busy_after_done", busy, 0);
        checkOutput("results_left", sb.size(), 0);
    endtask

    initial begin
        logic [31:0] c0, t0;
        #2;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_valid", pix_valid, 0);
        checkOutput("rst_x", pix_x, 0);
        checkOutput("rst_y", pix_y, 0);
        checkOutput("rst_iter", pix_iter, 0);
        checkOutput("rst_step_z", step_z, 0);
        #20;
        rst_n = 1'b1;

        $display("[TB] thres=0 raster frame");
        applyStimulus($urandom, 32'd0, 0, 0, 1, 1);
        waitDone();

        $display("[TB] identity stub, z0=0 pixel escapes at 3");
        applyStimulus(32'h0000_0001, 32'd3, 1, 0, 1, 1);
        waitDone();

        $display("[TB] never escaping, saturate at MAX_ITER");
        applyStimulus($urandom, 32'hFFFF_FFFF, 2, 0, 1, 1);
        waitDone();

        $display("[TB] backpressure hold");
        applyStimulus(32'h0000_0001, 32'd0, 1, 0, 0, 0);
        for (int i = 0; i < 100 && !pix_valid; i++) @(negedge clk);
        checkOutput("valid_seen", pix_valid, 1);
        repeat (5) @(negedge clk);
        checkOutput("valid_stalled", pix_valid, 1);
        ready_force = 1;
        waitDone();

        $display("[TB] random frames with random backpressure");
        for (int f = 0; f < 4; f++) begin
            applyStimulus($urandom, $urandom >> $urandom_range(8, 31), 0, 1, 1, 0);
            waitDone();
        end

        $display("[TB] start while busy is ignored");
        c0 = $urandom;
        t0 = $urandom >> 14;
        applyStimulus(c0, t0, 0, 0, 1, 1);
        repeat (6) @(posedge clk);
        #1;
        c = ~c0;
        thres = ~t0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone();
        repeat (5) @(negedge clk);
        checkOutput("no_second_frame", busy, 0);

        $display("[TB] reset mid-iteration on pixel (2,1)");
        applyStimulus($urandom, 32'hFFFF_FFFF, 2, 0, 1, 0);
        for (int i = 0; i < 2000 && !(pix_x == 12'd2 && pix_y == 12'd1 && !pix_valid); i++)
            @(negedge clk);
        checkOutput("reached_pixel_2_1", (pix_x == 12'd2) && (pix_y == 12'd1), 1);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_valid", pix_valid, 0);
        checkOutput("mid_rst_x", pix_x, 0);
        checkOutput("mid_rst_y", pix_y, 0);
        checkOutput("mid_rst_step_z", step_z, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("mid_rst_no_done", done_cnt, 0);
        checkOutput("mid_rst_idle", busy, 0);
        applyStimulus($urandom, $urandom >> 12, 0, 0, 1, 1);
        waitDone();

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
